intlv_buf: RTL and testbench

Ping-pong symbol buffer of the HPGP turbo interleaver, directly downstream of `gen_en`. Each duobinary symbol pair arriving with `gen_en`'s write strobe is stored in natural order at the supplied RAM address. The block then reads the completed block back in permuted order, using an external permutation ROM indexed by `pb_offset` + read count. The permuted symbol stream goes out on a valid/ready interface to the constituent encoder.

---
 rtl/intlv_buf.sv | 185 ++++++++++++++++++
 tb/tb_intlv_buf.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intlv_buf.sv
// intlv_buf: ping-pong symbol buffer for the turbo interleaver.
// Symbols arrive in natural order from gen_en and are stored in the write bank. A completed
// bank is read back in permuted order through an external permutation ROM and streamed out
// on a valid/ready interface.
//
// Ports:
//   clk, n_rst         clock, asynchronous active-low reset
//   wr_vld, wr_addr    write strobe and natural-order index
//   len_l, pb_offset   block length and ROM table base, latched at wr_addr = 0
//   din                symbol pair to store
//   rom_addr, rom_en   permutation ROM read port
//   rom_data           permuted index, valid one cycle after rom_en is sampled
//   dout, dout_vld     interleaved symbol stream
//   dout_rdy           downstream accept
//   dout_last          final symbol of the block
//   bank_full          per-bank full flags
//   err_drop           pulse: write discarded
//   err_idx            pulse: permuted index out of range
module intlv_buf #(
    parameter int unsigned ADDRESS = 12,
    parameter int unsigned DEPTH   = 2080,
    parameter int unsigned DW      = 2
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               wr_vld,
    input  logic [ADDRESS-1:0] wr_addr,
    input  logic [ADDRESS-1:0] len_l,
    input  logic [ADDRESS-1:0] pb_offset,
    input  logic [DW-1:0]      din,
    output logic [ADDRESS-1:0] rom_addr,
    output logic               rom_en,
    input  logic [ADDRESS-1:0] rom_data,
    output logic [DW-1:0]      dout,
    output logic               dout_vld,
    input  logic               dout_rdy,
    output logic               dout_last,
    output logic [1:0]         bank_full,
    output logic               err_drop,
    output logic               err_idx
);

    // DEPTH must fit in ADDRESS bits.
    localparam logic [ADDRESS-1:0] DEPTH_A = ADDRESS'(DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_RUN, R_FLUSH} rd_state_e;

    logic [DW-1:0]      mem [2][DEPTH];
    logic [ADDRESS-1:0] desc_len [2];
    logic [ADDRESS-1:0] desc_off [2];
    logic               wb, rb;

    // ---------------- Write side ----------------
    logic               first_wr, len_bad, addr_bad, wr_acc, wr_end;
    logic [ADDRESS-1:0] wr_len;

    always_comb begin
        first_wr = (wr_addr == '0);
        len_bad  = first_wr && ((len_l == '0) || (len_l > DEPTH_A));
        addr_bad = (wr_addr >= DEPTH_A);
        wr_acc   = wr_vld && !bank_full[wb] && !len_bad && !addr_bad;
        // A length-1 block completes on its first write, before the descriptor is latched.
        wr_len   = first_wr ? len_l : desc_len[wb];
        wr_end   = wr_acc && (wr_addr == wr_len - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wb][wr_addr] <= din;
        end
    end

    // ---------------- Read FSM ----------------
    rd_state_e          state_q, state_d;
    logic [ADDRESS-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDRESS-1:0] rd_len, rd_off;
    logic               stall, rd_last, rd_free, v1, l1, idx_bad;

    always_comb begin
        rd_len   = desc_len[rb];
        rd_off   = desc_off[rb];
        stall    = dout_vld && !dout_rdy;
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        rom_en   = 1'b0;
        rom_addr = '0;
        rd_last  = 1'b0;
        rd_free  = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (bank_full[rb]) begin
                    state_d  = R_RUN;
                    rd_cnt_d = '0;
                end
            end
            R_RUN: begin
                rom_addr = rd_off + rd_cnt_q;
                rom_en   = !stall;
                rd_last  = (rd_cnt_q == rd_len - 1'b1);
                if (!stall) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_last) begin
                        state_d = R_FLUSH;
                    end
                end
            end
            R_FLUSH: begin
                // The bank stays owned by the reader until its final symbol is taken.
                if (dout_vld && dout_rdy && dout_last) begin
                    rd_free = 1'b1;
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= R_IDLE;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // ---------------- Bank bookkeeping ----------------
    // Set and clear never hit the same bank: writes need a clear flag, the reader a set one.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bank_full   <= 2'b00;
            wb          <= 1'b0;
            rb          <= 1'b0;
            err_drop    <= 1'b0;
            desc_len[0] <= '0;
            desc_len[1] <= '0;
            desc_off[0] <= '0;
            desc_off[1] <= '0;
        end else begin
            err_drop <= wr_vld && !wr_acc;
            if (wr_acc && first_wr) begin
                desc_len[wb] <= len_l;
                desc_off[wb] <= pb_offset;
            end
            if (wr_end) begin
                bank_full[wb] <= 1'b1;
                wb            <= !wb;
            end
            if (rd_free) begin
                bank_full[rb] <= 1'b0;
                rb            <= !rb;
            end
        end
    end

    // ---------------- Output pipeline ----------------
    // Stage 1 is the ROM itself (v1/l1 track it); stage 2 is the symbol register.
    // On a stall everything holds, and the ROM holds rom_data because rom_en is low.
    assign idx_bad = (rom_data >= rd_len);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            v1        <= 1'b0;
            l1        <= 1'b0;
            dout      <= '0;
            dout_vld  <= 1'b0;
            dout_last <= 1'b0;
            err_idx   <= 1'b0;
        end else begin
            err_idx <= 1'b0;
            if (!stall) begin
                v1        <= rom_en;
                l1        <= rom_en && rd_last;
                dout_vld  <= v1;
                dout_last <= l1;
                if (v1) begin
                    dout    <= idx_bad ? '0 : mem[rb][rom_data];
                    err_idx <= idx_bad;
                end
            end
        end
    end

endmodule

// File: tb/tb_intlv_buf.sv
// Bench for intlv_buf: random symbols, behavioural ROM, and a scoreboard that derives each
// block's expected output as data[rom[offset + i]] (or 0 when the index is out of range).
module tb_intlv_buf;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        wr_vld = 1'b0;
    logic [11:0] wr_addr = '0;
    logic [11:0] len_l = '0;
    logic [11:0] pb_offset = '0;
    logic [1:0]  din = '0;
    logic [11:0] rom_addr;
    logic        rom_en;
    logic [11:0] rom_data = '0;
    logic [1:0]  dout;
    logic        dout_vld;
    logic        dout_rdy = 1'b0;
    logic        dout_last;
    logic [1:0]  bank_full;
    logic        err_drop;
    logic        err_idx;

    always #5 clk = ~clk;

    intlv_buf dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .wr_vld    (wr_vld),
        .wr_addr   (wr_addr),
        .len_l     (len_l),
        .pb_offset (pb_offset),
        .din       (din),
        .rom_addr  (rom_addr),
        .rom_en    (rom_en),
        .rom_data  (rom_data),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .dout_last (dout_last),
        .bank_full (bank_full),
        .err_drop  (err_drop),
        .err_idx   (err_idx)
    );

    typedef struct packed {
        logic [1:0] d;
        logic       last;
    } exp_t;

    logic [11:0] rom_mem [4096];
    logic [1:0]  blk [2080];
    exp_t        exp_q [$];
    logic [11:0] rom_q [$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          err_seen = 0;
    int          err_exp = 0;
    int          rdy_mode = 1;  // 0 low, 1 high, 2 random with 30% low

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Downstream ready driver.
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0) dout_rdy = 1'b0;
        else if (rdy_mode == 1) dout_rdy = 1'b1;
        else dout_rdy = ($urandom_range(0, 99) >= 30);
    end

    // Permutation ROM: address sampled with rom_en, data returned after the edge.
    initial begin
        logic        pend;
        logic [11:0] a;
        forever begin
            @(negedge clk);
            pend = 1'b0;
            if (n_rst && rom_en) begin
                pend = 1'b1;
                a    = rom_addr;
                if (rom_q.size() == 0) chk("rom_addr_unexpected", {20'd0, rom_addr}, 32'hffff_ffff);
                else chk("rom_addr", {20'd0, rom_addr}, {20'd0, rom_q.pop_front()});
            end
            @(posedge clk);
            #1;
            if (pend && n_rst) rom_data = rom_mem[a];
        end
    end

    // Output monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (n_rst) begin
                if (err_idx) err_seen++;
                if (dout_vld && dout_rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("dout_unexpected", {30'd0, dout}, 32'hffff_ffff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dout", {30'd0, dout}, {30'd0, e.d});
                        chk("dout_last", {31'd0, dout_last}, {31'd0, e.last});
                    end
                end
            end
        end
    end

    task automatic wr(input logic [11:0] a, input logic [1:0] d, input logic [11:0] l,
                      input logic [11:0] o, input bit exp_drop, input string name);
        @(negedge clk);
        wr_vld    = 1'b1;
        wr_addr   = a;
        din       = d;
        len_l     = l;
        pb_offset = o;
        @(posedge clk);
        #1;
        wr_vld = 1'b0;
        chk(name, {31'd0, err_drop}, {31'd0, exp_drop});
    endtask

    // Writes one block; random data when rnd, else wr_addr[1:0]. Pushes expectations if push.
    task automatic wr_block(input int len, input logic [11:0] off, input bit rnd,
                            input bit exp_drop, input bit push);
        logic [11:0] ra, idx;
        exp_t        e;
        for (int i = 0; i < len; i++) begin
            blk[i] = rnd ? 2'($urandom_range(0, 3)) : 2'(i);
            wr(12'(i), blk[i], 12'(len), off, exp_drop, "err_drop");
        end
        if (push) begin
            for (int i = 0; i < len; i++) begin
                ra  = 12'(off + 12'(i));
                idx = rom_mem[ra];
                rom_q.push_back(ra);
                if (int'(idx) < len) e.d = blk[idx];
                else begin
                    e.d = 2'd0;
                    err_exp++;
                end
                e.last = (i == len - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || rom_q.size() != 0) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_drain"}, exp_q.size(), 0);
        repeat (5) @(negedge clk);
        chk({name, "_bank_free"}, {30'd0, bank_full}, 0);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_rom_addr"}, {20'd0, rom_addr}, 0);
        chk({name, "_rom_en"}, {31'd0, rom_en}, 0);
        chk({name, "_dout"}, {30'd0, dout}, 0);
        chk({name, "_dout_vld"}, {31'd0, dout_vld}, 0);
        chk({name, "_dout_last"}, {31'd0, dout_last}, 0);
        chk({name, "_bank_full"}, {30'd0, bank_full}, 0);
        chk({name, "_err_drop"}, {31'd0, err_drop}, 0);
        chk({name, "_err_idx"}, {31'd0, err_idx}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k, t, g;
        bit  seen;
        for (int i = 0; i < 4096; i++) rom_mem[i] = '0;
        for (int i = 0; i < 10; i++) begin
            rom_mem[i]          = 12'(i);
            rom_mem[12'hb00 + i] = 12'(i);
        end
        for (int i = 0; i < 544; i++) rom_mem[12'h040 + i] = 12'((i * 13) % 544);
        for (int i = 0; i < 2080; i++) rom_mem[12'h260 + i] = 12'((i * 17 + 5) % 2080);

        rdy_mode = 1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        n_rst = 1'b1;

        // Illegal writes are dropped and leave the banks untouched.
        wr(12'h000, 2'd1, 12'h000, 12'h000, 1'b1, "drop_len_zero");
        wr(12'h000, 2'd1, 12'h900, 12'h000, 1'b1, "drop_len_big");
        wr(12'h820, 2'd1, 12'h00a, 12'h000, 1'b1, "drop_addr_big");
        @(negedge clk);
        chk("drops_bank_full", {30'd0, bank_full}, 0);

        // Identity ROM, length 10.
        wr_block(10, 12'h000, 1'b0, 1'b0, 1'b1);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!dout_vld && k < 10);
        chk("first_vld_latency", k, 3);
        drain("identity");

        // PB16 with a *13 permutation, ready held high.
        for (int i = 0; i < 64; i++) rom_mem[i] = 12'((i * 13) % 64);
        wr_block(64, 12'h000, 1'b1, 1'b0, 1'b1);
        drain("pb16");

        // Same block under random backpressure.
        rdy_mode = 2;
        wr_block(64, 12'h000, 1'b1, 1'b0, 1'b1);
        drain("pb16_bp");
        rdy_mode = 1;

        // Out-of-range permuted indices, including the exact boundary.
        rom_mem[5]  = 12'h050;
        rom_mem[41] = 12'h040;
        wr_block(64, 12'h000, 1'b1, 1'b0, 1'b1);
        drain("pb16_idx");
        chk("err_idx_count", err_seen, err_exp);
        rom_mem[5]  = 12'((5 * 13) % 64);
        rom_mem[41] = 12'((41 * 13) % 64);

        // Back-to-back PB136 then PB520; hold ready low until both banks are full.
        rdy_mode = 0;
        wr_block(544, 12'h040, 1'b1, 1'b0, 1'b1);
        wr_block(2080, 12'h260, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("b2b_bank_full", {30'd0, bank_full}, 3);
        rdy_mode = 1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(dout_vld && dout_rdy && dout_last) && t < 5000);
        chk("b2b_first_last_seen", {31'd0, (t < 5000)}, 1);
        @(posedge clk);
        g    = 0;
        seen = 1'b0;
        while (g < 10) begin
            @(negedge clk);
            if (rom_en && !seen) begin
                chk("b2b_second_rom_addr", {20'd0, rom_addr}, 32'h260);
                seen = 1'b1;
            end
            if (dout_vld) break;
            g++;
        end
        chk("b2b_gap", g, 3);
        chk("b2b_rom_seen", {31'd0, seen}, 1);
        drain("b2b");

        // Overflow: both banks filled with ready low, third block is dropped.
        rdy_mode = 0;
        wr_block(10, 12'hb00, 1'b1, 1'b0, 1'b1);
        wr_block(10, 12'hb00, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("ovf_bank_full", {30'd0, bank_full}, 3);
        wr_block(10, 12'hb00, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("ovf_bank_full_after", {30'd0, bank_full}, 3);
        rdy_mode = 1;
        drain("overflow");

        // Reset in the middle of a stream.
        wr_block(64, 12'h000, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        exp_q.delete();
        rom_q.delete();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        wr_block(64, 12'h000, 1'b1, 1'b0, 1'b1);
        drain("recover");
        chk("err_idx_count_final", err_seen, err_exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
